// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: valid/ready-handshaked MEM stage for the 32-bit RISC-V
// 5-stage pipeline, in front of an internal word-addressed data RAM with a
// configurable access latency. Handles lb/lh/lw/lbu/lhu/sb/sh/sw with
// little-endian byte lanes. Flags misaligned and out-of-range accesses and
// suppresses their side effects.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   in_valid/in_ready   EXE -> stage handshake
//   in_mem_op           0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 8 sb, 9 sh, 10 sw
//   in_addr             byte address (ALU result)
//   in_wdata            store data
//   in_imm, in_rd, in_regwrite, in_memtoreg  sideband carried to WB
//   out_valid/out_ready stage -> WB handshake
//   out_rdata           extended load data (0 for non-loads and errors)
//   out_alu, out_imm, out_rd, out_memtoreg   carried sideband
//   out_regwrite        in_regwrite, cleared on misalign/fault
//   out_misalign        access misaligned
//   out_fault           word index out of range
//   stall               in_valid & ~in_ready
module mem_stage_pipe #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_mem_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic [1:0]  in_memtoreg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [31:0] out_alu,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_regwrite,
    output logic [1:0]  out_memtoreg,
    output logic        out_misalign,
    output logic        out_fault,
    output logic        stall
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [30:0] LP_DEPTH = 31'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_addr, r_wdata, r_imm;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic [1:0]  r_memtoreg;
    logic [31:0] r_mem [DEPTH];

    function automatic logic f_is_load(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        case (op)
            4'd8, 4'd9, 4'd10: return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

    logic        w_accept, w_direct, w_done_edge, w_from_busy;
    logic [3:0]  w_op;
    logic [31:0] w_addr, w_wdata, w_imm;
    logic [4:0]  w_rd;
    logic        w_regwrite;
    logic [1:0]  w_memtoreg;
    logic        w_is_load, w_is_store, w_is_byte, w_is_half, w_is_word;
    logic        w_misalign, w_fault, w_ok;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word, w_shift, w_lanes, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign stall     = in_valid & ~in_ready;
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid & in_ready;

    // Ops that need no wait state complete on their own acceptance edge, so
    // the RAM access then uses the live inputs instead of the latched copy.
    assign w_direct    = (WAIT_CYCLES == 0) || !(f_is_load(in_mem_op) || f_is_store(in_mem_op));
    assign w_from_busy = (r_state == BUSY);
    assign w_done_edge = (w_from_busy && (r_cnt == 4'd1)) || (w_accept && w_direct);

    assign w_op       = w_from_busy ? r_op       : in_mem_op;
    assign w_addr     = w_from_busy ? r_addr     : in_addr;
    assign w_wdata    = w_from_busy ? r_wdata    : in_wdata;
    assign w_imm      = w_from_busy ? r_imm      : in_imm;
    assign w_rd       = w_from_busy ? r_rd       : in_rd;
    assign w_regwrite = w_from_busy ? r_regwrite : in_regwrite;
    assign w_memtoreg = w_from_busy ? r_memtoreg : in_memtoreg;

    assign w_is_load  = f_is_load(w_op);
    assign w_is_store = f_is_store(w_op);
    assign w_is_byte  = (w_op == 4'd1) || (w_op == 4'd4) || (w_op == 4'd8);
    assign w_is_half  = (w_op == 4'd2) || (w_op == 4'd5) || (w_op == 4'd9);
    assign w_is_word  = (w_op == 4'd3) || (w_op == 4'd10);

    assign w_misalign = (w_is_half && w_addr[0]) || (w_is_word && (w_addr[1:0] != 2'b00));
    assign w_fault    = (w_is_load || w_is_store) && ({1'b0, w_addr[31:2]} >= LP_DEPTH);
    assign w_ok       = ~w_misalign & ~w_fault;

    assign w_idx   = w_addr[AW+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = '0;
        case (w_op)
            4'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
            4'd4:    w_load_data = {24'd0, w_byte};
            4'd2:    w_load_data = {{16{w_half[15]}}, w_half};
            4'd5:    w_load_data = {16'd0, w_half};
            4'd3:    w_load_data = w_word;
            default: w_load_data = '0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        w_lanes = w_wdata;
        w_be    = '0;
        if (w_is_byte) begin
            w_lanes = {4{w_wdata[7:0]}};
            w_be    = 4'b0001 << w_addr[1:0];
        end else if (w_is_half) begin
            w_lanes = {2{w_wdata[15:0]}};
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        end else if (w_is_word) begin
            w_be    = 4'b1111;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = w_direct ? DONE : BUSY;
            BUSY: if (r_cnt == 4'd1) w_state_next = DONE;
            DONE: if (out_ready) begin
                if (in_valid) w_state_next = w_direct ? DONE : BUSY;
                else          w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_imm        <= '0;
            r_rd         <= '0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= '0;
            out_rdata    <= '0;
            out_alu      <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
            out_memtoreg <= '0;
            out_misalign <= 1'b0;
            out_fault    <= 1'b0;
        end else begin
            if (w_accept && !w_direct) begin
                r_op       <= in_mem_op;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_imm      <= in_imm;
                r_rd       <= in_rd;
                r_regwrite <= in_regwrite;
                r_memtoreg <= in_memtoreg;
                r_cnt      <= LP_WAIT;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done_edge) begin
                out_rdata    <= (w_is_load && w_ok) ? w_load_data : '0;
                out_alu      <= w_addr;
                out_imm      <= w_imm;
                out_rd       <= w_rd;
                out_regwrite <= w_regwrite & w_ok;
                out_memtoreg <= w_memtoreg;
                out_misalign <= w_misalign;
                out_fault    <= w_fault;
            end
        end
    end

    // RAM contents are not reset; a reset on the commit edge cancels the store.
    always_ff @(posedge clock) begin
        if (!reset && w_done_edge && w_is_store && w_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Testbench for mem_stage_pipe: two instances (WAIT_CYCLES 0 and 3, DEPTH 64)
// driven by directed and random ops, checked every cycle against a
// transaction-level model of the stage and its RAM.
module tb_mem_stage_pipe;

    localparam int unsigned DEPTH = 64;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd8, OP_SH = 4'd9,
                           OP_SW = 4'd10;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst      [2];
    logic        i_valid  [2];
    logic        i_ready  [2];
    logic [3:0]  i_op     [2];
    logic [31:0] i_addr   [2];
    logic [31:0] i_wdata  [2];
    logic [31:0] i_imm    [2];
    logic [4:0]  i_rd     [2];
    logic        i_rw     [2];
    logic [1:0]  i_m2r    [2];
    logic        o_valid  [2];
    logic        o_ready  [2];
    logic [31:0] o_rdata  [2];
    logic [31:0] o_alu    [2];
    logic [31:0] o_imm    [2];
    logic [4:0]  o_rd     [2];
    logic        o_rw     [2];
    logic [1:0]  o_m2r    [2];
    logic        o_mis    [2];
    logic        o_fault  [2];
    logic        o_stall  [2];

    mem_stage_pipe #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .reset(rst[0]),
        .in_valid(i_valid[0]), .in_ready(i_ready[0]), .in_mem_op(i_op[0]),
        .in_addr(i_addr[0]), .in_wdata(i_wdata[0]), .in_imm(i_imm[0]),
        .in_rd(i_rd[0]), .in_regwrite(i_rw[0]), .in_memtoreg(i_m2r[0]),
        .out_valid(o_valid[0]), .out_ready(o_ready[0]), .out_rdata(o_rdata[0]),
        .out_alu(o_alu[0]), .out_imm(o_imm[0]), .out_rd(o_rd[0]),
        .out_regwrite(o_rw[0]), .out_memtoreg(o_m2r[0]),
        .out_misalign(o_mis[0]), .out_fault(o_fault[0]), .stall(o_stall[0])
    );

    mem_stage_pipe #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clock(clock), .reset(rst[1]),
        .in_valid(i_valid[1]), .in_ready(i_ready[1]), .in_mem_op(i_op[1]),
        .in_addr(i_addr[1]), .in_wdata(i_wdata[1]), .in_imm(i_imm[1]),
        .in_rd(i_rd[1]), .in_regwrite(i_rw[1]), .in_memtoreg(i_m2r[1]),
        .out_valid(o_valid[1]), .out_ready(o_ready[1]), .out_rdata(o_rdata[1]),
        .out_alu(o_alu[1]), .out_imm(o_imm[1]), .out_rd(o_rd[1]),
        .out_regwrite(o_rw[1]), .out_memtoreg(o_m2r[1]),
        .out_misalign(o_mis[1]), .out_fault(o_fault[1]), .stall(o_stall[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] @cyc %0d: got %h, expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] rdata, alu, imm, nword;
        logic [4:0]  rd;
        logic [1:0]  m2r;
        logic        rw, mis, fault, rknown, store, kafter, committed;
        int          vcyc;
        int          widx;
    } exp_t;

    exp_t        pend     [2];
    bit          has      [2];
    logic [31:0] mmem     [2][DEPTH];
    bit          mknown   [2][DEPTH];

    int          hcount   [2];
    int          hcyc     [2];
    int          prev_hcyc[2];
    int          rise_cyc [2];
    int          acc_cyc  [2];
    logic        prev_valid[2];
    logic [31:0] last_rdata[2];
    logic        last_mis [2];
    logic        last_fault[2];
    logic        last_rw  [2];

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int bytes_of(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    task automatic predict(input int k);
        exp_t        e;
        int          nb, off;
        logic [31:0] w, v, mask;
        nb  = bytes_of(i_op[k]);
        off = int'(i_addr[k][1:0]);
        e.alu = i_addr[k];  e.imm = i_imm[k];  e.rd = i_rd[k];  e.m2r = i_m2r[k];
        e.mis   = (nb > 1) && ((off % nb) != 0);
        e.fault = (nb > 0) && ((i_addr[k] >> 2) >= DEPTH);
        e.rw    = i_rw[k] && !e.mis && !e.fault;
        e.rdata = 32'd0;  e.rknown = 1'b1;  e.store = 1'b0;  e.kafter = 1'b0;
        e.committed = 1'b0;  e.nword = 32'd0;  e.widx = 0;
        if (nb > 0 && !e.mis && !e.fault) begin
            e.widx = int'(i_addr[k] >> 2);
            w    = mmem[k][e.widx];
            mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (i_op[k] < 4'd8) begin
                if (!mknown[k][e.widx]) e.rknown = 1'b0;
                v = (w >> (8 * off)) & mask;
                if ((i_op[k] == OP_LB || i_op[k] == OP_LH) && v[8*nb-1]) v = v | ~mask;
                e.rdata = v;
            end else begin
                e.store  = 1'b1;
                e.kafter = mknown[k][e.widx] || (nb == 4);
                for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = i_wdata[k][8*i +: 8];
                e.nword = w;
            end
        end
        e.vcyc = cyc + ((nb > 0) ? wait_of(k) + 1 : 1);
        pend[k] = e;
        has[k]  = 1'b1;
    endtask

    // Single compare process: every cycle, both instances.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit ev;
            bit er;
            if (rst[k]) begin
                has[k]        = 1'b0;
                prev_valid[k] = 1'b0;
            end else begin
                if (has[k] && !pend[k].committed && cyc >= pend[k].vcyc) begin
                    if (pend[k].store) begin
                        mmem[k][pend[k].widx]   = pend[k].nword;
                        mknown[k][pend[k].widx] = pend[k].kafter;
                    end
                    pend[k].committed = 1'b1;
                end
                ev = has[k] && (cyc >= pend[k].vcyc);
                er = !has[k] || (ev && o_ready[k]);
                chk("out_valid", k, 32'(o_valid[k]), 32'(ev));
                chk("in_ready",  k, 32'(i_ready[k]), 32'(er));
                chk("stall",     k, 32'(o_stall[k]), 32'(i_valid[k] & ~er));
                if (ev) begin
                    chk("out_alu",      k, o_alu[k],          pend[k].alu);
                    chk("out_imm",      k, o_imm[k],          pend[k].imm);
                    chk("out_rd",       k, 32'(o_rd[k]),      32'(pend[k].rd));
                    chk("out_memtoreg", k, 32'(o_m2r[k]),     32'(pend[k].m2r));
                    chk("out_regwrite", k, 32'(o_rw[k]),      32'(pend[k].rw));
                    chk("out_misalign", k, 32'(o_mis[k]),     32'(pend[k].mis));
                    chk("out_fault",    k, 32'(o_fault[k]),   32'(pend[k].fault));
                    if (pend[k].rknown) chk("out_rdata", k, o_rdata[k], pend[k].rdata);
                end
                if (o_valid[k] && !prev_valid[k]) rise_cyc[k] = cyc;
                prev_valid[k] = o_valid[k];
                if (o_valid[k] && o_ready[k]) begin
                    hcount[k]++;
                    prev_hcyc[k]  = hcyc[k];
                    hcyc[k]       = cyc;
                    last_rdata[k] = o_rdata[k];
                    last_mis[k]   = o_mis[k];
                    last_fault[k] = o_fault[k];
                    last_rw[k]    = o_rw[k];
                end
                if (ev && o_ready[k]) has[k] = 1'b0;
                if (i_valid[k] && er) begin
                    predict(k);
                    acc_cyc[k] = cyc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    int mode[2];   // out_ready: 0 low, 1 high, 2 random

    initial begin
        o_ready[0] = 1'b1;
        o_ready[1] = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++)
                o_ready[k] = (mode[k] == 0) ? 1'b0 :
                             (mode[k] == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int k, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] imm, input logic [4:0] rd,
                        input logic rw, input logic [1:0] m2r, output int nwait);
        bit got;
        got = 1'b0;
        nwait = 0;
        i_op[k] = op;  i_addr[k] = addr;  i_wdata[k] = wdata;  i_imm[k] = imm;
        i_rd[k] = rd;  i_rw[k] = rw;  i_m2r[k] = m2r;  i_valid[k] = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clock);
            if (i_ready[k]) begin
                got = 1'b1;
                break;
            end
            nwait++;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout[inst %0d]: in_ready stayed 0 for 64 cycles, expected 1", k);
        end
        @(posedge clock);
        #1;
        i_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        for (int n = 0; n < 100; n++) begin
            if (!has[k]) return;
            @(posedge clock);
            #2;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout[inst %0d]: result still pending after 100 cycles, expected 0", k);
    endtask

    task automatic sd(input int k, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int nw;
        send(k, op, addr, wdata, $urandom, 5'($urandom), 1'b1, 2'($urandom), nw);
    endtask

    task automatic random_phase(input int k, input int nops);
        logic [3:0]  op_tbl [14];
        logic [31:0] addr;
        int          nw;
        op_tbl = '{OP_NONE, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                   4'd6, 4'd7, 4'd11, 4'd12, 4'd15};
        mode[k] = 1;
        for (int w = 0; w < 16; w++) sd(k, OP_SW, 32'(w * 4), $urandom);
        mode[k] = 2;
        for (int n = 0; n < nops; n++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
                1:       addr = $urandom | 32'h8000_0000;
                default: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            send(k, op_tbl[$urandom_range(0, 13)], addr, $urandom, $urandom,
                 5'($urandom), 1'($urandom), 2'($urandom), nw);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
            if (n % 20 == 19) mode[k] = $urandom_range(1, 2);
        end
        mode[k] = 1;
        drain(k);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int nw, a, hc0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;  i_valid[k] = 1'b0;  i_op[k] = '0;  i_addr[k] = '0;
            i_wdata[k] = '0;  i_imm[k] = '0;  i_rd[k] = '0;  i_rw[k] = 1'b0;
            i_m2r[k] = '0;  mode[k] = 1;  hcount[k] = 0;  hcyc[k] = 0;  prev_hcyc[k] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid",    k, 32'(o_valid[k]), 32'd0);
            chk("rst_in_ready",     k, 32'(i_ready[k]), 32'd1);
            chk("rst_out_rdata",    k, o_rdata[k],      32'd0);
            chk("rst_out_alu",      k, o_alu[k],        32'd0);
            chk("rst_out_imm",      k, o_imm[k],        32'd0);
            chk("rst_out_rd",       k, 32'(o_rd[k]),    32'd0);
            chk("rst_out_regwrite", k, 32'(o_rw[k]),    32'd0);
            chk("rst_out_memtoreg", k, 32'(o_m2r[k]),   32'd0);
            chk("rst_out_flags",    k, 32'({o_mis[k], o_fault[k]}), 32'd0);
        end
        @(posedge clock);
        #1;

        // ---- WAIT_CYCLES = 0 ----
        send(0, OP_SW, 32'h10, 32'hDEAD_BEEF, 32'h1, 5'd1, 1'b0, 2'd0, nw);
        send(0, OP_LW, 32'h10, 32'h0, 32'h2, 5'd2, 1'b1, 2'd1, nw);
        chk("b2b_nowait", 0, 32'(nw), 32'd0);
        drain(0);
        chk("b2b_lw_rdata", 0, last_rdata[0], 32'hDEAD_BEEF);
        chk("b2b_spacing",  0, 32'(hcyc[0] - prev_hcyc[0]), 32'd1);

        sd(0, OP_SW, 32'h0, 32'h0102_0304);
        sd(0, OP_SW, 32'h20, 32'h1122_3344);
        sd(0, OP_SB, 32'h21, 32'h0000_00AA);
        sd(0, OP_LB, 32'h21, 32'h0);
        drain(0);
        chk("lb_rdata", 0, last_rdata[0], 32'hFFFF_FFAA);
        sd(0, OP_LBU, 32'h21, 32'h0);
        drain(0);
        chk("lbu_rdata", 0, last_rdata[0], 32'h0000_00AA);
        sd(0, OP_LH, 32'h22, 32'h0);
        drain(0);
        chk("lh_rdata", 0, last_rdata[0], 32'h0000_1122);
        sd(0, OP_LW, 32'h20, 32'h0);
        drain(0);
        chk("lw_merged", 0, last_rdata[0], 32'h1122_AA44);

        sd(0, OP_LW, 32'h22, 32'h0);
        drain(0);
        chk("mis_flag",  0, 32'(last_mis[0]), 32'd1);
        chk("mis_rw",    0, 32'(last_rw[0]),  32'd0);
        chk("mis_rdata", 0, last_rdata[0],    32'd0);
        sd(0, OP_SW, 32'(4 * DEPTH), 32'hCAFE_F00D);
        drain(0);
        chk("fault_flag", 0, 32'(last_fault[0]), 32'd1);
        sd(0, OP_LW, 32'h0, 32'h0);
        drain(0);
        chk("fault_word0", 0, last_rdata[0], 32'h0102_0304);

        // ---- WAIT_CYCLES = 3 ----
        sd(1, OP_SW, 32'h30, 32'h0BAD_F00D);
        drain(1);
        send(1, OP_LW, 32'h30, 32'h0, 32'h100, 5'd3, 1'b1, 2'd1, nw);
        a = acc_cyc[1];
        send(1, OP_LW, 32'h30, 32'h0, 32'h101, 5'd4, 1'b1, 2'd1, nw);
        chk("busy_stall_cycles", 1, 32'(nw), 32'd3);
        chk("wait3_latency", 1, 32'(rise_cyc[1] - a), 32'd4);
        drain(1);
        chk("wait3_rdata", 1, last_rdata[1], 32'h0BAD_F00D);

        mode[1] = 0;
        hc0 = hcount[1];
        send(1, OP_LW, 32'h30, 32'h0, 32'h111, 5'd5, 1'b1, 2'd1, nw);
        repeat (10) @(posedge clock);
        #1;
        mode[1] = 1;
        send(1, OP_SW, 32'h34, 32'h77, 32'h222, 5'd6, 1'b0, 2'd0, nw);
        drain(1);
        chk("bp_handoffs", 1, 32'(hcount[1] - hc0), 32'd2);

        sd(1, OP_SW, 32'h30, 32'h55);
        rst[1] = 1'b1;
        @(posedge clock);
        #1;
        rst[1] = 1'b0;
        @(negedge clock);
        chk("rst_abort_valid", 1, 32'(o_valid[1]), 32'd0);
        @(posedge clock);
        #1;
        sd(1, OP_LW, 32'h30, 32'h0);
        drain(1);
        chk("rst_abort_rdata", 1, last_rdata[1], 32'h0BAD_F00D);

        // ---- randomized ----
        random_phase(0, 200);
        random_phase(1, 120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
